// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and lane helpers for the data-memory bus controller.
// mem_func_e codes are the ones the MEM stage drives on mem_func_i.
package mem_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    MF_BS = 3'd0,
    MF_BU = 3'd1,
    MF_HS = 3'd2,
    MF_HU = 3'd3,
    MF_WD = 3'd4,
    MF_WL = 3'd5,
    MF_WR = 3'd6
  } mem_func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  // Byte enables; lane n corresponds to byte address n (little-endian).
  function automatic logic [3:0] lane_be(mem_func_e f, logic [1:0] a);
    case (f)
      MF_BS, MF_BU: lane_be = 4'b0001 << a;
      MF_HS, MF_HU: lane_be = 4'b0011 << {a[1], 1'b0};
      MF_WD:        lane_be = 4'b1111;
      MF_WL:        lane_be = 4'b1111 >> (2'd3 - a);
      MF_WR:        lane_be = 4'b1111 << a;
      default:      lane_be = 4'b0000;
    endcase
  endfunction

  // Store data replicated or shifted so the enabled lanes carry the right bytes.
  function automatic logic [31:0] lane_wdata(mem_func_e f, logic [1:0] a, logic [31:0] d);
    logic [4:0] sh_l_s;
    logic [4:0] sh_r_s;
    sh_l_s = {2'd3 - a, 3'b000};
    sh_r_s = {a, 3'b000};
    case (f)
      MF_BS, MF_BU: lane_wdata = {4{d[7:0]}};
      MF_HS, MF_HU: lane_wdata = {2{d[15:0]}};
      MF_WD:        lane_wdata = d;
      MF_WL:        lane_wdata = d >> sh_l_s;
      MF_WR:        lane_wdata = d << sh_r_s;
      default:      lane_wdata = 32'h0000_0000;
    endcase
  endfunction

  // Extract/extend load data; LWL/LWR merge the unloaded bytes from old Rt.
  function automatic logic [31:0] lane_load(mem_func_e f, logic [1:0] a,
                                            logic [31:0] rdata, logic [31:0] rt);
    logic [31:0] byte_s;
    logic [31:0] half_s;
    logic [4:0]  sh_l_s;
    logic [4:0]  sh_r_s;
    byte_s = rdata >> {a, 3'b000};
    half_s = rdata >> {a[1], 4'b0000};
    sh_l_s = {2'd3 - a, 3'b000};
    sh_r_s = {a, 3'b000};
    case (f)
      MF_BS:   lane_load = {{24{byte_s[7]}}, byte_s[7:0]};
      MF_BU:   lane_load = {24'h00_0000, byte_s[7:0]};
      MF_HS:   lane_load = {{16{half_s[15]}}, half_s[15:0]};
      MF_HU:   lane_load = {16'h0000, half_s[15:0]};
      MF_WD:   lane_load = rdata;
      MF_WL:   lane_load = (rdata << sh_l_s) | (rt & ~(32'hFFFF_FFFF << sh_l_s));
      MF_WR:   lane_load = (rdata >> sh_r_s) | (rt & ~(32'hFFFF_FFFF >> sh_r_s));
      default: lane_load = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// External data-bus bundle: req/ack handshake plus address/data/enables.
interface mem_bus_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_bus_ctrl_align.sv
// Combinational lane logic: byte enables, positioned store data and
// extracted/merged load data for one access.
module mem_bus_ctrl_align
  import mem_bus_ctrl_pkg::*;
(
  input  mem_func_e   func_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] rt_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  assign be_o    = lane_be(func_i, addr_lo_i);
  assign wdata_o = lane_wdata(func_i, addr_lo_i, wdata_i);
  assign load_o  = lane_load(func_i, addr_lo_i, rdata_i, rt_i);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller behind the MEM stage: runs one req/ack bus
// transaction per load/store, stalls the pipeline meanwhile and returns the
// aligned load result. Optional macro MEM_ALIGN_CHECK_EN rejects misaligned
// half/word accesses with a bus error instead of issuing a bus cycle.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_read_i,
  input  logic           mem_write_i,
  input  logic [2:0]     mem_func_i,
  input  logic [31:0]    addr_i,
  input  logic [31:0]    mem_write_data_i,
  input  logic           write_l_i,
  input  logic           write_r_i,
  input  logic [31:0]    rt_data_i,
  output logic           stall_o,
  output logic [31:0]    load_data_o,
  output logic           load_valid_o,
  output logic           bus_err_o,
  mem_bus_ctrl_if.master bus
);

  localparam logic [15:0] CNT_LAST = 16'(MAX_WAIT - 1);

  bus_state_e  state_q, state_d;
  mem_func_e   func_q, func_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rt_q, rt_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        load_valid_q, load_valid_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] load_data_q, load_data_d;

  logic        acc_s;
  logic        misalign_s;
  logic        timeout_s;
  mem_func_e   eff_func_s;
  logic [3:0]  be_s;
  logic [31:0] lane_wdata_s;
  logic [31:0] load_s;

  // WriteL/WriteR flags from the MEM stage override the func code.
  assign eff_func_s = write_l_i ? MF_WL : (write_r_i ? MF_WR : mem_func_e'(mem_func_i));
  assign acc_s      = mem_read_i | mem_write_i;
  assign timeout_s  = (cnt_q == CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = (((eff_func_s == MF_HS) || (eff_func_s == MF_HU)) && addr_i[0]) ||
                      ((eff_func_s == MF_WD) && (addr_i[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  mem_bus_ctrl_align u_align (
    .func_i    (func_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (bus.mem_rdata),
    .rt_i      (rt_q),
    .be_o      (be_s),
    .wdata_o   (lane_wdata_s),
    .load_o    (load_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE -> REQ (or DONE on misalignment) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acc_s) begin
          state_d = misalign_s ? DONE : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_ack || timeout_s) begin
          state_d = DONE;
        end else begin
          state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for captured request fields, wait counter and outputs.
  always_comb begin
    func_d       = func_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rt_d         = rt_q;
    is_wr_d      = is_wr_q;
    cnt_d        = cnt_q;
    req_d        = 1'b0;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    load_data_d  = load_data_q;
    case (state_q)
      IDLE: begin
        if (acc_s) begin
          func_d  = eff_func_s;
          addr_d  = addr_i;
          wdata_d = mem_write_data_i;
          rt_d    = rt_data_i;
          is_wr_d = mem_write_i;
          cnt_d   = 16'd0;
          if (misalign_s) begin
            bus_err_d   = 1'b1;
            load_data_d = 32'h0000_0000;
          end else begin
            req_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          load_valid_d = ~is_wr_q;
          load_data_d  = is_wr_q ? load_data_q : load_s;
        end else if (timeout_s) begin
          bus_err_d   = 1'b1;
          load_data_d = 32'h0000_0000;
        end else begin
          req_d = 1'b1;
          cnt_d = 16'(cnt_q + 16'd1);
        end
      end
      DONE:    cnt_d = cnt_q;
      default: cnt_d = 16'd0;
    endcase
  end

  // Request-field, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      func_q       <= MF_BS;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      rt_q         <= 32'h0000_0000;
      is_wr_q      <= 1'b0;
      cnt_q        <= 16'd0;
      req_q        <= 1'b0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      load_data_q  <= 32'h0000_0000;
    end else begin
      func_q       <= func_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rt_q         <= rt_d;
      is_wr_q      <= is_wr_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
      load_data_q  <= load_data_d;
    end
  end

  // Bus fields are driven only while the request is up, zero otherwise.
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = req_q & is_wr_q;
  assign bus.mem_addr  = req_q ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
  assign bus.mem_be    = req_q ? be_s : 4'b0000;
  assign bus.mem_wdata = req_q ? lane_wdata_s : 32'h0000_0000;

  // Stall drops in DONE so the pipeline advances on the completing cycle.
  assign stall_o      = (state_q == REQ) | ((state_q == IDLE) & acc_s);
  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl (MAX_WAIT=4) with a scoreboard queue.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  typedef struct {
    int          stall_cnt;
    int          req_cnt;
    int          lv_cnt;
    int          err_cnt;
    int          lv_cyc;
    int          done_ok;
    logic [31:0] ld;
    logic [31:0] ld_end;
    logic [31:0] wd;
    logic [31:0] ad;
    logic [3:0]  be;
    logic        we;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  mem_func = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        write_l = 1'b0;
  logic        write_r = 1'b0;
  logic [31:0] rt = 32'h0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  obs_t exp_q[$];

  mem_bus_ctrl_if bus_if ();

  mem_bus_ctrl #(.MAX_WAIT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read_i       (mem_read),
    .mem_write_i      (mem_write),
    .mem_func_i       (mem_func),
    .addr_i           (addr),
    .mem_write_data_i (wdata),
    .write_l_i        (write_l),
    .write_r_i        (write_r),
    .rt_data_i        (rt),
    .stall_o          (stall),
    .load_data_o      (load_data),
    .load_valid_o     (load_valid),
    .bus_err_o        (bus_err),
    .bus              (bus_if.master)
  );

  always #5 clk = ~clk;

  // Drive one access from an IDLE cycle and observe it until Stall drops.
  // ack_at = REQ cycle (1-based) on which MemAck is returned; 0 = never.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] fn,
                         input logic wl, input logic wrr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rt_v,
                         input logic [31:0] rdat, input int ack_at, output obs_t o);
    o = '{default: '0};
    mem_read = rd; mem_write = wr; mem_func = fn; write_l = wl; write_r = wrr;
    addr = a; wdata = d; rt = rt_v;
    @(negedge clk);
    if (stall) o.stall_cnt++;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; write_l = 1'b0; write_r = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      if (stall) o.stall_cnt++;
      if (bus_if.mem_req) begin
        o.req_cnt++;
        o.be = bus_if.mem_be; o.wd = bus_if.mem_wdata;
        o.ad = bus_if.mem_addr; o.we = bus_if.mem_we;
        if (o.req_cnt == ack_at) begin
          bus_if.mem_ack = 1'b1;
          bus_if.mem_rdata = rdat;
        end
      end
      if (load_valid) begin o.lv_cnt++; o.lv_cyc = c; o.ld = load_data; end
      if (bus_err) o.err_cnt++;
      if (!stall) begin o.done_ok = 1; o.ld_end = load_data; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({stall, load_valid, bus_err, load_data} !== 35'h0)
      $display("FAIL reset_pipe: got %h exp 0", {stall, load_valid, bus_err, load_data});
    else pass_cnt++;
    chk_cnt++;
    if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_be, bus_if.mem_wdata} !== 70'h0)
      $display("FAIL reset_bus: got %h exp 0",
               {bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_be, bus_if.mem_wdata});
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_store_word();
    obs_t e, o;
    e = '{default: '0};
    e.stall_cnt = 4; e.be = 4'b1111; e.wd = 32'hDEAD_BEEF; e.ad = 32'h100; e.we = 1'b1; e.done_ok = 1;
    exp_q.push_back(e);
    run_txn(1'b0, 1'b1, MF_WD, 1'b0, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 32'h0, 3, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if (o.be !== e.be) $display("FAIL sw_be: got %b exp %b", o.be, e.be); else pass_cnt++;
    chk_cnt++;
    if (o.wd !== e.wd) $display("FAIL sw_wdata: got %h exp %h", o.wd, e.wd); else pass_cnt++;
    chk_cnt++;
    if ({o.ad, o.we} !== {e.ad, e.we}) $display("FAIL sw_addr_we: got %h/%b exp %h/%b", o.ad, o.we, e.ad, e.we); else pass_cnt++;
    chk_cnt++;
    if (o.stall_cnt != e.stall_cnt) $display("FAIL sw_stall: got %0d exp %0d", o.stall_cnt, e.stall_cnt); else pass_cnt++;
    chk_cnt++;
    if (o.lv_cnt != 0 || o.done_ok != 1) $display("FAIL sw_done: lv %0d done %0d exp 0/1", o.lv_cnt, o.done_ok); else pass_cnt++;
  endtask

  task automatic test_load_byte();
    obs_t e, o;
    logic [2:0] fns [2];
    logic [31:0] res [2];
    fns[0] = MF_BS; res[0] = 32'hFFFF_FF80;
    fns[1] = MF_BU; res[1] = 32'h0000_0080;
    for (int i = 0; i < 2; i++) begin
      e = '{default: '0};
      e.ld = res[i]; e.lv_cyc = 2; e.lv_cnt = 1; e.be = 4'b1000; e.ad = 32'h100;
      exp_q.push_back(e);
      run_txn(1'b1, 1'b0, fns[i], 1'b0, 1'b0, 32'h103, 32'h0, 32'h0, 32'h8011_2233, 1, o);
      e = exp_q.pop_front();
      chk_cnt++;
      if (o.ld !== e.ld) $display("FAIL lb_data%0d: got %h exp %h", i, o.ld, e.ld); else pass_cnt++;
      chk_cnt++;
      if (o.lv_cyc != e.lv_cyc || o.lv_cnt != e.lv_cnt)
        $display("FAIL lb_latency%0d: got cyc %0d cnt %0d exp %0d/%0d", i, o.lv_cyc, o.lv_cnt, e.lv_cyc, e.lv_cnt);
      else pass_cnt++;
      chk_cnt++;
      if ({o.be, o.ad, o.we} !== {e.be, e.ad, 1'b0}) $display("FAIL lb_bus%0d: got %b %h exp %b %h", i, o.be, o.ad, e.be, e.ad); else pass_cnt++;
    end
  endtask

  task automatic test_lwl_lwr();
    obs_t e, o;
    e = '{default: '0}; e.ld = 32'h3344_CCDD; e.be = 4'b0011;
    exp_q.push_back(e);
    e = '{default: '0}; e.ld = 32'hAABB_1122; e.be = 4'b1100;
    exp_q.push_back(e);
    run_txn(1'b1, 1'b0, MF_WD, 1'b1, 1'b0, 32'h201, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({o.ld, o.be} !== {e.ld, e.be}) $display("FAIL lwl: got %h %b exp %h %b", o.ld, o.be, e.ld, e.be); else pass_cnt++;
    run_txn(1'b1, 1'b0, MF_WD, 1'b0, 1'b1, 32'h202, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 2, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({o.ld, o.be} !== {e.ld, e.be}) $display("FAIL lwr: got %h %b exp %h %b", o.ld, o.be, e.ld, e.be); else pass_cnt++;
  endtask

  task automatic test_swr_half();
    obs_t e, o;
    e = '{default: '0}; e.be = 4'b1110; e.wd = 32'h3456_7800;
    exp_q.push_back(e);
    run_txn(1'b0, 1'b1, MF_WD, 1'b0, 1'b1, 32'h301, 32'h1234_5678, 32'h0, 32'h0, 1, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({o.be, o.wd} !== {e.be, e.wd}) $display("FAIL swr: got %b %h exp %b %h", o.be, o.wd, e.be, e.wd); else pass_cnt++;
    e = '{default: '0}; e.be = 4'b1100; e.wd = 32'hABCD_ABCD;
    exp_q.push_back(e);
    run_txn(1'b0, 1'b1, MF_HU, 1'b0, 1'b0, 32'h102, 32'h1234_ABCD, 32'h0, 32'h0, 1, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({o.be, o.wd} !== {e.be, e.wd}) $display("FAIL sh: got %b %h exp %b %h", o.be, o.wd, e.be, e.wd); else pass_cnt++;
    e = '{default: '0}; e.ld = 32'hFFFF_8001; e.be = 4'b1100;
    exp_q.push_back(e);
    run_txn(1'b1, 1'b0, MF_HS, 1'b0, 1'b0, 32'h102, 32'h0, 32'h0, 32'h8001_7FFF, 1, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({o.ld, o.be} !== {e.ld, e.be}) $display("FAIL lh: got %h %b exp %h %b", o.ld, o.be, e.ld, e.be); else pass_cnt++;
    e = '{default: '0}; e.ld = 32'h0000_7FFF; e.be = 4'b0011;
    exp_q.push_back(e);
    run_txn(1'b1, 1'b0, MF_HU, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h8001_7FFF, 1, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({o.ld, o.be} !== {e.ld, e.be}) $display("FAIL lhu: got %h %b exp %h %b", o.ld, o.be, e.ld, e.be); else pass_cnt++;
  endtask

  task automatic test_timeout();
    obs_t e, o;
    e = '{default: '0}; e.err_cnt = 1; e.req_cnt = 4; e.stall_cnt = 5; e.done_ok = 1;
    exp_q.push_back(e);
    run_txn(1'b1, 1'b0, MF_WD, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 32'h0, 0, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if (o.err_cnt != e.err_cnt || o.lv_cnt != 0) $display("FAIL to_err: err %0d lv %0d exp 1/0", o.err_cnt, o.lv_cnt); else pass_cnt++;
    chk_cnt++;
    if (o.req_cnt != e.req_cnt || o.stall_cnt != e.stall_cnt)
      $display("FAIL to_req: req %0d stall %0d exp %0d/%0d", o.req_cnt, o.stall_cnt, e.req_cnt, e.stall_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (o.ld_end !== 32'h0 || o.done_ok != 1) $display("FAIL to_data: got %h done %0d exp 0/1", o.ld_end, o.done_ok); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({stall, bus_if.mem_req, bus_err} !== 3'b000) $display("FAIL to_idle: got %b exp 000", {stall, bus_if.mem_req, bus_err}); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    mem_read = 1'b1; mem_func = MF_WD; addr = 32'h480;
    @(posedge clk); #1 mem_read = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (bus_if.mem_req !== 1'b1) $display("FAIL rm_req: got %b exp 1", bus_if.mem_req); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({bus_if.mem_req, stall, load_valid, bus_err} !== 4'b0000)
      $display("FAIL rm_abort: got %b exp 0000", {bus_if.mem_req, stall, load_valid, bus_err});
    else pass_cnt++;
    @(posedge clk); #1;
    e = '{default: '0}; e.ld = 32'hCAFE_F00D; e.lv_cnt = 1; e.ad = 32'h500;
    exp_q.push_back(e);
    run_txn(1'b1, 1'b0, MF_WD, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, 32'hCAFE_F00D, 2, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({o.ld, o.ad} !== {e.ld, e.ad} || o.lv_cnt != e.lv_cnt)
      $display("FAIL rm_fresh: got %h %h lv %0d exp %h %h lv %0d", o.ld, o.ad, o.lv_cnt, e.ld, e.ad, e.lv_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    logic [31:0] a, rd;
    int ack;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; rd = $urandom; ack = $urandom_range(1, 3);
      e = '{default: '0}; e.lv_cnt = 1; e.lv_cyc = ack + 1;
      case (a[1:0])
        2'd0:    e.ld = {24'h0, rd[7:0]};
        2'd1:    e.ld = {24'h0, rd[15:8]};
        2'd2:    e.ld = {24'h0, rd[23:16]};
        default: e.ld = {24'h0, rd[31:24]};
      endcase
      exp_q.push_back(e);
      run_txn(1'b1, 1'b0, MF_BU, 1'b0, 1'b0, a, 32'h0, 32'h0, rd, ack, o);
      e = exp_q.pop_front();
      chk_cnt++;
      if (o.ld !== e.ld || o.lv_cnt != e.lv_cnt || o.lv_cyc != e.lv_cyc)
        $display("FAIL b2b%0d: got %h lv %0d cyc %0d exp %h lv %0d cyc %0d",
                 i, o.ld, o.lv_cnt, o.lv_cyc, e.ld, e.lv_cnt, e.lv_cyc);
      else pass_cnt++;
    end
  endtask

  task automatic test_align();
    obs_t e, o;
`ifdef MEM_ALIGN_CHECK_EN
    e = '{default: '0}; e.err_cnt = 1; e.stall_cnt = 1;
    exp_q.push_back(e);
    run_txn(1'b1, 1'b0, MF_WD, 1'b0, 1'b0, 32'h602, 32'h0, 32'h0, 32'h1357_9BDF, 1, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if (o.err_cnt != e.err_cnt || o.req_cnt != 0 || o.lv_cnt != 0 || o.stall_cnt != e.stall_cnt)
      $display("FAIL misalign: err %0d req %0d lv %0d stall %0d exp 1/0/0/1", o.err_cnt, o.req_cnt, o.lv_cnt, o.stall_cnt);
    else pass_cnt++;
`else
    e = '{default: '0}; e.ld = 32'h1357_9BDF; e.ad = 32'h600; e.be = 4'b1111;
    exp_q.push_back(e);
    run_txn(1'b1, 1'b0, MF_WD, 1'b0, 1'b0, 32'h602, 32'h0, 32'h0, 32'h1357_9BDF, 1, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({o.ld, o.ad, o.be} !== {e.ld, e.ad, e.be} || o.err_cnt != 0)
      $display("FAIL unaligned_lw: got %h %h %b err %0d exp %h %h %b err 0", o.ld, o.ad, o.be, o.err_cnt, e.ld, e.ad, e.be);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_lwl_lwr();
    test_swr_half();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_align();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
